// File: rtl/retire_trace_pkg.sv
// Shared types and constants for the retire trace transmitter.
// FSM encoding, header bit map, summary word order, FIFO entry layout.
package retire_trace_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_WDATA = 4'd1;
  localparam logic [3:0] ST_ADDR  = 4'd2;
  localparam logic [3:0] ST_MDATA = 4'd3;
  localparam logic [3:0] ST_SUM0  = 4'd4;
  localparam logic [3:0] ST_SUM5  = 4'd9;
  localparam logic [3:0] ST_DONE  = 4'd10;

  localparam int HDR_HALT    = 15;
  localparam int HDR_REGWR   = 14;
  localparam int HDR_MEMRD   = 13;
  localparam int HDR_MEMWR   = 12;
  localparam int HDR_WREG_LO = 9;
  localparam int SEQ_W       = 9;

  localparam logic [2:0] SUM_CYCLE = 3'd0;
  localparam logic [2:0] SUM_INST  = 3'd1;
  localparam logic [2:0] SUM_DCHIT = 3'd2;
  localparam logic [2:0] SUM_ICHIT = 3'd3;
  localparam logic [2:0] SUM_DCREQ = 3'd4;
  localparam logic [2:0] SUM_ICREQ = 3'd5;

  typedef struct packed {
    logic             halt;
    logic             regwr;
    logic             memrd;
    logic             memwr;
    logic [2:0]       wreg;
    logic [15:0]      wdata;
    logic [15:0]      addr;
    logic [15:0]      mdata;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic logic [15:0] hdr_word(input entry_t e);
    logic [15:0] h;
    h = '0;
    h[HDR_HALT]  = e.halt;
    h[HDR_REGWR] = e.regwr;
    h[HDR_MEMRD] = e.memrd;
    h[HDR_MEMWR] = e.memwr;
    h[HDR_WREG_LO +: 3] = e.wreg;
    h[SEQ_W-1:0] = e.seq;
    return h;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of 2.
// Ports: clk, rst, push/din, pop/dout (head), full, empty, count.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/retire_trace_tx.sv
// Retire event trace transmitter: captures MEM/WB events, serializes
// 16-bit record words on a valid/ready port, then a counter summary after halt.
// Ports: clk, rst, ret_* retire event inputs, ic/dc cache strobes,
// trace_ready in; trace_valid/data/last, trace_stall, trace_ovf, trace_done out.
module retire_trace_tx
  import retire_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ret_regwr,
  input  logic [2:0]  ret_wreg,
  input  logic [15:0] ret_wdata,
  input  logic        ret_memrd,
  input  logic        ret_memwr,
  input  logic [15:0] ret_addr,
  input  logic [15:0] ret_stdata,
  input  logic [15:0] ret_lddata,
  input  logic        ret_halt,
  input  logic        ic_req,
  input  logic        ic_hit,
  input  logic        dc_req,
  input  logic        dc_hit,
  input  logic        trace_ready,
  output logic        trace_valid,
  output logic [15:0] trace_data,
  output logic        trace_last,
  output logic        trace_stall,
  output logic        trace_ovf,
  output logic        trace_done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]       state;
  logic [3:0]       state_nx;
  logic             halted;
  logic [SEQ_W-1:0] seq;
  logic             ovf;
  logic             stall_q;

  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] inst_cnt;
  logic [CNT_W-1:0] dch_cnt;
  logic [CNT_W-1:0] ich_cnt;
  logic [CNT_W-1:0] dcr_cnt;
  logic [CNT_W-1:0] icr_cnt;

  logic               cap;
  entry_t             ent_in;
  entry_t             head;
  logic [ENTRY_W-1:0] head_bits;
  logic               f_full;
  logic               f_empty;
  logic [AW:0]        f_count;
  logic               pop;
  logic               head_mem;
  logic               valid;
  logic               last;
  logic [15:0]        word;
  logic [15:0]        sum_word;
  logic [2:0]         sum_sel;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign cap = ~halted & (ret_regwr | ret_memrd | ret_memwr | ret_halt);

  // A simultaneous load+store is recorded as a store.
  always_comb begin
    ent_in       = '0;
    ent_in.halt  = ret_halt;
    ent_in.regwr = ret_regwr;
    ent_in.memrd = ret_memrd & ~ret_memwr;
    ent_in.memwr = ret_memwr;
    ent_in.wreg  = ret_wreg;
    ent_in.wdata = ret_wdata;
    ent_in.addr  = ret_addr;
    ent_in.mdata = ret_memwr ? ret_stdata : ret_lddata;
    ent_in.seq   = seq;
  end

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap),
    .din   (ent_in),
    .pop   (pop),
    .dout  (head_bits),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign head     = entry_t'(head_bits);
  assign head_mem = head.memrd | head.memwr;
  assign sum_sel  = 3'(state - ST_SUM0);

  always_comb begin
    sum_word = '0;
    unique case (sum_sel)
      SUM_CYCLE: sum_word = 16'(cyc_cnt);
      SUM_INST:  sum_word = 16'(inst_cnt);
      SUM_DCHIT: sum_word = 16'(dch_cnt);
      SUM_ICHIT: sum_word = 16'(ich_cnt);
      SUM_DCREQ: sum_word = 16'(dcr_cnt);
      SUM_ICREQ: sum_word = 16'(icr_cnt);
      default:   sum_word = '0;
    endcase
  end

  // The header is presented straight from the FIFO head so a record can
  // start the cycle after capture; the record pops on its final word.
  always_comb begin
    valid    = 1'b0;
    last     = 1'b0;
    word     = '0;
    pop      = 1'b0;
    state_nx = state;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (!f_empty) begin
          valid = 1'b1;
          word  = hdr_word(head);
          last  = ~head.regwr & ~head_mem;
          if (trace_ready) begin
            if (head.regwr)   state_nx = ST_WDATA;
            else if (head_mem) state_nx = ST_ADDR;
            else               pop = 1'b1;
          end
        end else if (halted) begin
          // halt record was dropped on overflow: still emit the summary
          state_nx = ST_SUM0;
        end
      end
      (state == ST_WDATA): begin
        valid = 1'b1;
        word  = head.wdata;
        last  = ~head_mem;
        if (trace_ready) begin
          if (head_mem) state_nx = ST_ADDR;
          else          pop = 1'b1;
        end
      end
      (state == ST_ADDR): begin
        valid = 1'b1;
        word  = head.addr;
        if (trace_ready) state_nx = ST_MDATA;
      end
      (state == ST_MDATA): begin
        valid = 1'b1;
        word  = head.mdata;
        last  = 1'b1;
        if (trace_ready) pop = 1'b1;
      end
      (state >= ST_SUM0 && state <= ST_SUM5): begin
        valid = 1'b1;
        word  = sum_word;
        last  = (state == ST_SUM5);
        if (trace_ready) state_nx = state + 4'd1;
      end
      default: state_nx = state;
    endcase
    if (pop) state_nx = head.halt ? ST_SUM0 : ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      halted   <= 1'b0;
      seq      <= '0;
      ovf      <= 1'b0;
      stall_q  <= 1'b0;
      cyc_cnt  <= '0;
      inst_cnt <= '0;
      dch_cnt  <= '0;
      ich_cnt  <= '0;
      dcr_cnt  <= '0;
      icr_cnt  <= '0;
    end else begin
      state   <= state_nx;
      stall_q <= (f_count >= (AW+1)'(FIFO_DEPTH-1));
      if (cap) begin
        seq <= seq + 1'b1;
        if (f_full)   ovf    <= 1'b1;
        if (ret_halt) halted <= 1'b1;
      end
      cyc_cnt  <= sat_inc(cyc_cnt, ~halted);
      inst_cnt <= sat_inc(inst_cnt,
                          ~halted & (ret_halt | ret_regwr | ret_memwr));
      dch_cnt  <= sat_inc(dch_cnt, ~halted & dc_hit);
      ich_cnt  <= sat_inc(ich_cnt, ~halted & ic_hit);
      dcr_cnt  <= sat_inc(dcr_cnt, ~halted & dc_req);
      icr_cnt  <= sat_inc(icr_cnt, ~halted & ic_req);
    end
  end

  assign trace_valid = valid;
  assign trace_data  = word;
  assign trace_last  = last;
  assign trace_stall = stall_q;
  assign trace_ovf   = ovf;
  assign trace_done  = (state == ST_DONE);

endmodule

// File: tb/tb_retire_trace_tx.sv
// Directed bench for retire_trace_tx with hand-computed records.
// Collects accepted words into a queue and checks them by index.
module tb_retire_trace_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        ret_regwr;
  logic [2:0]  ret_wreg;
  logic [15:0] ret_wdata;
  logic        ret_memrd;
  logic        ret_memwr;
  logic [15:0] ret_addr;
  logic [15:0] ret_stdata;
  logic [15:0] ret_lddata;
  logic        ret_halt;
  logic        ic_req;
  logic        ic_hit;
  logic        dc_req;
  logic        dc_hit;
  logic        trace_ready;
  logic        trace_valid;
  logic [15:0] trace_data;
  logic        trace_last;
  logic        trace_stall;
  logic        trace_ovf;
  logic        trace_done;

  logic [16:0] q[$];
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  retire_trace_tx dut (
    .clk         (clk),
    .rst         (rst),
    .ret_regwr   (ret_regwr),
    .ret_wreg    (ret_wreg),
    .ret_wdata   (ret_wdata),
    .ret_memrd   (ret_memrd),
    .ret_memwr   (ret_memwr),
    .ret_addr    (ret_addr),
    .ret_stdata  (ret_stdata),
    .ret_lddata  (ret_lddata),
    .ret_halt    (ret_halt),
    .ic_req      (ic_req),
    .ic_hit      (ic_hit),
    .dc_req      (dc_req),
    .dc_hit      (dc_hit),
    .trace_ready (trace_ready),
    .trace_valid (trace_valid),
    .trace_data  (trace_data),
    .trace_last  (trace_last),
    .trace_stall (trace_stall),
    .trace_ovf   (trace_ovf),
    .trace_done  (trace_done)
  );

  always @(negedge clk)
    if (trace_valid && trace_ready) q.push_back({trace_last, trace_data});

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] w(input logic v, input logic l,
                                    input logic [15:0] d);
    return {14'b0, v, l, d};
  endfunction

  function automatic logic [31:0] ow();
    return {14'b0, trace_valid, trace_last, trace_data};
  endfunction

  function automatic logic [31:0] qw(input int i);
    if (i >= q.size()) return 32'hDEAD_0000;
    return 32'(q[i]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ret_regwr = 0; ret_wreg = 0; ret_wdata = 0;
    ret_memrd = 0; ret_memwr = 0; ret_addr = 0;
    ret_stdata = 0; ret_lddata = 0; ret_halt = 0;
    ic_req = 0; ic_hit = 0; dc_req = 0; dc_hit = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    q.delete();
  endtask

  task automatic ev_regwr(input logic [2:0] r, input logic [15:0] d);
    ret_regwr = 1;
    ret_wreg  = r;
    ret_wdata = d;
    tick();
    clr_in();
  endtask

  task automatic drain(input int max, input string tag);
    int n;
    n = 0;
    while (trace_valid && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(trace_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    logic [16:0] eh;
    logic [16:0] ew;
    logic [8:0]  k9;
    clr_in();
    trace_ready = 0;

    // reset state
    do_reset();
    check("rst_word", ow(), w(0, 0, 16'h0));
    check("rst_stall", 32'(trace_stall), 0);
    check("rst_ovf", 32'(trace_ovf), 0);
    check("rst_done", 32'(trace_done), 0);

    // single regwr r3
    trace_ready = 1;
    ev_regwr(3'd3, 16'h1234);
    check("t1_hdr", ow(), w(1, 0, 16'h4600));
    tick();
    check("t1_wdata", ow(), w(1, 1, 16'h1234));
    tick();
    check("t1_idle", 32'(trace_valid), 0);

    // store with backpressure
    do_reset();
    trace_ready = 0;
    ret_memwr  = 1;
    ret_addr   = 16'h0040;
    ret_stdata = 16'hBEEF;
    ret_lddata = 16'h1111;
    tick();
    clr_in();
    for (int i = 0; i < 3; i++) begin
      check("t2_hold", ow(), w(1, 0, 16'h1000));
      tick();
    end
    trace_ready = 1;
    check("t2_hdr", ow(), w(1, 0, 16'h1000));
    tick();
    check("t2_addr", ow(), w(1, 0, 16'h0040));
    tick();
    check("t2_mdata", ow(), w(1, 1, 16'hBEEF));
    tick();
    check("t2_idle", 32'(trace_valid), 0);

    // fill, stall, overflow
    do_reset();
    trace_ready = 0;
    for (int i = 0; i < 7; i++) ev_regwr(3'(i), 16'h0100 + 16'(i));
    check("t3_stall_lag", 32'(trace_stall), 0);
    ev_regwr(3'd7, 16'h0107);
    check("t3_stall", 32'(trace_stall), 1);
    check("t3_no_ovf", 32'(trace_ovf), 0);
    ev_regwr(3'd0, 16'h0108);
    check("t3_ovf", 32'(trace_ovf), 1);
    trace_ready = 1;
    drain(40, "t3_drain");
    check("t3_count", 32'(q.size()), 16);
    check("t3_q0", qw(0), w(0, 0, 16'h4000));
    check("t3_q1", qw(1), w(0, 1, 16'h0100));
    check("t3_q14", qw(14), w(0, 0, 16'h4E07));
    check("t3_q15", qw(15), w(0, 1, 16'h0107));
    check("t3_unstall", 32'(trace_stall), 0);
    check("t3_ovf_sticky", 32'(trace_ovf), 1);
    q.delete();
    ev_regwr(3'd0, 16'h0055);
    drain(10, "t3_drain2");
    check("t3_seq_skip", qw(0), w(0, 0, 16'h4009));

    // halt and summary
    do_reset();
    trace_ready = 1;
    for (int c = 1; c <= 10; c++) begin
      clr_in();
      if (c <= 4) begin
        ret_regwr = 1;
        ret_wreg  = 3'(c);
        ret_wdata = 16'(c);
      end
      if (c >= 5 && c <= 7) ic_req = 1;
      if (c == 5 || c == 6) ic_hit = 1;
      if (c == 10) ret_halt = 1;
      tick();
    end
    clr_in();
    n = 0;
    while (!trace_done && n < 100) begin
      tick();
      n++;
    end
    check("t4_done", 32'(trace_done), 1);
    check("t4_count", 32'(q.size()), 15);
    check("t4_q0", qw(0), w(0, 0, 16'h4200));
    check("t4_q1", qw(1), w(0, 1, 16'h0001));
    check("t4_halt_hdr", qw(8), w(0, 1, 16'h8004));
    check("t4_cycle", qw(9), w(0, 0, 16'd10));
    check("t4_inst", qw(10), w(0, 0, 16'd5));
    check("t4_dchit", qw(11), w(0, 0, 16'd0));
    check("t4_ichit", qw(12), w(0, 0, 16'd2));
    check("t4_dcreq", qw(13), w(0, 0, 16'd0));
    check("t4_icreq", qw(14), w(0, 1, 16'd3));
    ev_regwr(3'd2, 16'h0099);
    tick();
    tick();
    check("t4_ignored", 32'(q.size()), 15);
    check("t4_idle", 32'(trace_valid), 0);
    check("t4_done_hold", 32'(trace_done), 1);

    // reset from done, then mid-record
    rst = 1;
    tick();
    check("t5_done_clr", 32'(trace_done), 0);
    rst = 0;
    trace_ready = 1;
    ev_regwr(3'd5, 16'hAAAA);
    check("t5_hdr", ow(), w(1, 0, 16'h4A00));
    tick();
    check("t5_wdata", ow(), w(1, 1, 16'hAAAA));
    rst = 1;
    tick();
    check("t5_rst_word", ow(), w(0, 0, 16'h0));
    check("t5_rst_flags",
          {29'b0, trace_stall, trace_ovf, trace_done}, 0);
    rst = 0;
    trace_ready = 0;
    ev_regwr(3'd5, 16'hAAAA);
    check("t5_seq0", ow(), w(1, 0, 16'h4A00));

    // 513 events, seq wrap
    do_reset();
    trace_ready = 1;
    for (int k = 0; k < 513; k++) begin
      ret_regwr = 1;
      ret_wreg  = 3'd1;
      ret_wdata = 16'(k);
      tick();
      clr_in();
      tick();
    end
    drain(20, "t6_drain");
    check("t6_count", 32'(q.size()), 1026);
    bad = 0;
    for (int k = 0; k < 513; k++) begin
      k9 = 9'(k);
      eh = {1'b0, 7'b0100001, k9};
      ew = {1'b1, 16'(k)};
      if (2 * k + 1 >= q.size()) bad++;
      else if (q[2*k] !== eh || q[2*k+1] !== ew) bad++;
    end
    check("t6_bad", 32'(bad), 0);
    check("t6_seq511", qw(1022), w(0, 0, 16'h43FF));
    check("t6_seq0", qw(1024), w(0, 0, 16'h4200));
    check("t6_no_ovf", 32'(trace_ovf), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
